rob_commit: RTL and testbench

- In-order reorder buffer for the Tomasulo core.
- Accepts one issued instruction per cycle from the issue stage: destination register plus reservation-station tag.
- Captures results from the CDB by tag and retires completed entries in program order, one per cycle.
- Its commit outputs feed the rename table's commit/to_zero_index/original_name inputs and the register-file write port.

---
 rtl/rob_commit.sv | 142 ++++++++++++++
 tb/tb_rob_commit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// rob_commit: in-order reorder buffer for the Tomasulo core.
// Issues at tail, captures CDB results by tag, retires from head.
module rob_commit #(
   parameter int DEPTH  = 8,
   parameter int IDX_W  = 3,
   parameter int TAG_W  = 4,
   parameter int REG_W  = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [REG_W-1:0]  issue_dest,
   input  logic [TAG_W-1:0]  issue_tag,
   output logic [IDX_W-1:0]  issue_idx,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   input  logic              flush,
   output logic              commit,
   output logic [REG_W-1:0]  commit_dest,
   output logic [TAG_W-1:0]  commit_tag,
   output logic [DATA_W-1:0] commit_data,
   output logic              commit_wen,
   output logic              empty,
   output logic [IDX_W:0]    count
);

   localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DEPTH-1:0]  done_q, done_d;
   logic [REG_W-1:0]  dest_q [DEPTH];
   logic [REG_W-1:0]  dest_d [DEPTH];
   logic [TAG_W-1:0]  tag_q  [DEPTH];
   logic [TAG_W-1:0]  tag_d  [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [IDX_W-1:0]  head_q, head_d;
   logic [IDX_W-1:0]  tail_q, tail_d;
   logic [IDX_W:0]    count_q, count_d;

   logic              accept;
   logic              retire;
   logic [DEPTH-1:0]  wb_hit;

   // Handshake and head-entry views, all from registered state.
   always_comb begin
      issue_ready = (count_q < FULL_CNT);
      issue_idx   = tail_q;
      accept      = issue_valid && issue_ready;
      retire      = valid_q[head_q] && done_q[head_q];
      commit      = retire;
      commit_dest = dest_q[head_q];
      commit_tag  = tag_q[head_q];
      commit_data = data_q[head_q];
      commit_wen  = retire && (dest_q[head_q] != '0);
      empty       = (count_q == '0) && (head_q == tail_q);
      count       = count_q;
   end

   // Tag match: only live, still-pending entries may capture a result.
   always_comb begin
      wb_hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wb_hit[i] = cdb_valid && valid_q[i] && !done_q[i] &&
                     (tag_q[i] == cdb_tag);
      end
   end

   // Next state: flush wins; otherwise writeback, retire, then allocate.
   always_comb begin
      valid_d = valid_q;
      done_d  = done_q;
      dest_d  = dest_q;
      tag_d   = tag_q;
      data_d  = data_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         valid_d = '0;
         done_d  = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wb_hit[i]) begin
               done_d[i] = 1'b1;
               data_d[i] = cdb_data;
            end
         end
         if (retire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
         end
         // The tail slot is free, so the writeback above never touched it.
         if (accept) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            dest_d[tail_q]  = issue_dest;
            tag_d[tail_q]   = issue_tag;
            tail_d          = tail_q + 1'b1;
         end
         unique case ({accept, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         done_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            dest_q[i] <= '0;
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         done_q  <= done_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            dest_q[i] <= dest_d[i];
            tag_q[i]  <= tag_d[i];
            data_q[i] <= data_d[i];
         end
      end
   end

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed plus random stimulus for rob_commit,
// checked against a queue-based program-order model.
module tb_rob_commit;

   localparam int DEPTH  = 8;
   localparam int IDX_W  = 3;
   localparam int TAG_W  = 4;
   localparam int REG_W  = 5;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              issue_valid = 1'b0;
   logic              issue_ready;
   logic [REG_W-1:0]  issue_dest = '0;
   logic [TAG_W-1:0]  issue_tag = '0;
   logic [IDX_W-1:0]  issue_idx;
   logic              cdb_valid = 1'b0;
   logic [TAG_W-1:0]  cdb_tag = '0;
   logic [DATA_W-1:0] cdb_data = '0;
   logic              flush = 1'b0;
   logic              commit;
   logic [REG_W-1:0]  commit_dest;
   logic [TAG_W-1:0]  commit_tag;
   logic [DATA_W-1:0] commit_data;
   logic              commit_wen;
   logic              empty;
   logic [IDX_W:0]    count;

   always #5 clk = ~clk;

   rob_commit #(
      .DEPTH(DEPTH), .IDX_W(IDX_W), .TAG_W(TAG_W),
      .REG_W(REG_W), .DATA_W(DATA_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_dest(issue_dest), .issue_tag(issue_tag),
      .issue_idx(issue_idx),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .flush(flush),
      .commit(commit), .commit_dest(commit_dest),
      .commit_tag(commit_tag), .commit_data(commit_data),
      .commit_wen(commit_wen), .empty(empty), .count(count)
   );

   typedef struct {
      logic [REG_W-1:0]  dest;
      logic [TAG_W-1:0]  tag;
      bit                done;
      logic [DATA_W-1:0] data;
   } ent_t;

   ent_t        mq[$];
   int unsigned m_tail = 0;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string name, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, obs, exp);
      end
   endtask

   task automatic check_all();
      bit mc;
      mc = (mq.size() > 0) && mq[0].done;
      chk("issue_ready", issue_ready, mq.size() < DEPTH);
      chk("issue_idx", issue_idx, m_tail % DEPTH);
      chk("count", count, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("commit", commit, mc);
      if (mc) begin
         chk("commit_dest", commit_dest, mq[0].dest);
         chk("commit_tag", commit_tag, mq[0].tag);
         chk("commit_data", commit_data, mq[0].data);
         chk("commit_wen", commit_wen, mq[0].dest != 0);
      end else begin
         chk("commit_wen_idle", commit_wen, 0);
      end
   endtask

   task automatic model_step();
      bit mc;
      bit acc;
      if (flush) begin
         mq.delete();
         m_tail = 0;
         return;
      end
      mc  = (mq.size() > 0) && mq[0].done;
      acc = issue_valid && (mq.size() < DEPTH);
      if (cdb_valid) begin
         foreach (mq[i]) begin
            if (!mq[i].done && mq[i].tag == cdb_tag) begin
               mq[i].done = 1'b1;
               mq[i].data = cdb_data;
            end
         end
      end
      if (mc) void'(mq.pop_front());
      if (acc) begin
         mq.push_back('{issue_dest, issue_tag, 1'b0, 32'd0});
         m_tail++;
      end
   endtask

   task automatic drive(input bit iv, input int d, input int t,
                        input bit cv, input int ct,
                        input logic [DATA_W-1:0] cd, input bit fl);
      issue_valid = iv;
      issue_dest  = d[REG_W-1:0];
      issue_tag   = t[TAG_W-1:0];
      cdb_valid   = cv;
      cdb_tag     = ct[TAG_W-1:0];
      cdb_data    = cd;
      flush       = fl;
      check_all();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 0, 0, 1'b0, 0, '0, 1'b0);
   endtask

   initial begin
      int ct;
      // Reset then idle
      repeat (2) @(posedge clk);
      #1;
      check_all();
      chk("rst_ready", issue_ready, 1);
      chk("rst_empty", empty, 1);
      chk("rst_commit", commit, 0);
      chk("rst_count", count, 0);
      rst_n = 1'b1;
      idle();

      // Single op
      drive(1'b1, 5, 3, 1'b0, 0, '0, 1'b0);
      drive(1'b0, 0, 0, 1'b1, 3, 32'hDEAD, 1'b0);
      chk("single_commit", commit, 1);
      chk("single_dest", commit_dest, 5);
      chk("single_tag", commit_tag, 3);
      chk("single_data", commit_data, 32'hDEAD);
      chk("single_wen", commit_wen, 1);
      idle();
      chk("single_count", count, 0);

      // Out-of-order completion, in-order retire
      drive(1'b1, 1, 1, 1'b0, 0, '0, 1'b0);
      drive(1'b1, 2, 2, 1'b0, 0, '0, 1'b0);
      drive(1'b0, 0, 0, 1'b1, 2, 32'h22, 1'b0);
      chk("ooo_hold", commit, 0);
      drive(1'b0, 0, 0, 1'b1, 1, 32'h11, 1'b0);
      chk("ooo_a", commit_data, 32'h11);
      idle();
      chk("ooo_b", commit_data, 32'h22);
      chk("ooo_b_commit", commit, 1);
      idle();
      chk("ooo_empty", empty, 1);

      // Full and wrap
      drive(1'b0, 0, 0, 1'b0, 0, '0, 1'b1);
      for (int i = 0; i < DEPTH; i++)
         drive(1'b1, i + 1, i + 1, 1'b0, 0, '0, 1'b0);
      chk("full_count", count, 8);
      chk("full_ready", issue_ready, 0);
      drive(1'b1, 20, 9, 1'b0, 0, '0, 1'b0);
      chk("full_ignored", count, 8);
      drive(1'b1, 20, 9, 1'b1, 1, 32'h100, 1'b0);
      chk("full_head_done", commit, 1);
      chk("full_no_bypass", issue_ready, 0);
      drive(1'b1, 20, 9, 1'b0, 0, '0, 1'b0);
      chk("wrap_ready", issue_ready, 1);
      chk("wrap_idx", issue_idx, 0);
      chk("wrap_count7", count, 7);
      drive(1'b1, 20, 9, 1'b0, 0, '0, 1'b0);
      chk("wrap_count8", count, 8);

      // Tag reuse and dest 0
      drive(1'b0, 0, 0, 1'b0, 0, '0, 1'b1);
      drive(1'b1, 0, 4, 1'b0, 0, '0, 1'b0);
      drive(1'b0, 0, 0, 1'b1, 4, 32'h44, 1'b0);
      chk("x_commit", commit, 1);
      chk("x_wen", commit_wen, 0);
      drive(1'b1, 7, 4, 1'b1, 4, 32'h55, 1'b0);
      chk("y_not_done", commit, 0);
      chk("y_count", count, 1);
      drive(1'b0, 0, 0, 1'b1, 4, 32'h77, 1'b0);
      chk("y_commit", commit, 1);
      chk("y_data", commit_data, 32'h77);
      chk("y_wen", commit_wen, 1);
      idle();

      // Flush
      for (int i = 0; i < 5; i++)
         drive(1'b1, 10 + i, i + 1, 1'b0, 0, '0, 1'b0);
      chk("pre_flush_count", count, 5);
      drive(1'b0, 0, 0, 1'b0, 0, '0, 1'b1);
      chk("flush_empty", empty, 1);
      chk("flush_count", count, 0);
      chk("flush_commit", commit, 0);
      drive(1'b0, 0, 0, 1'b1, 3, 32'hBAD, 1'b0);
      chk("flush_cdb_commit", commit, 0);
      chk("flush_cdb_count", count, 0);
      chk("flush_idx", issue_idx, 0);
      drive(1'b1, 3, 6, 1'b0, 0, '0, 1'b0);
      chk("post_flush_count", count, 1);

      // Random traffic with a mid-run asynchronous reset
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) begin
            issue_valid = 1'b0;
            cdb_valid   = 1'b0;
            flush       = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            chk("async_rst_count", count, 0);
            chk("async_rst_empty", empty, 1);
            chk("async_rst_commit", commit, 0);
            mq.delete();
            m_tail = 0;
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
         end
         ct = $urandom_range(1, 15);
         if (mq.size() > 0 && $urandom_range(0, 3) != 0)
            ct = int'(mq[$urandom_range(0, mq.size() - 1)].tag);
         drive($urandom_range(0, 2) != 0,
               $urandom_range(0, 31),
               $urandom_range(1, 15),
               $urandom_range(0, 1) != 0,
               ct,
               $urandom,
               $urandom_range(0, 59) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
